game_judge: RTL and testbench
=============================

# game_judge

Hit-judgement and scoring engine for game mode. It consumes the 10-bit `vga_bottom` lane bus from the note renderer, which carries one bit per lane set when a note block reaches the hit line, together with the player's key vector. For every note it decides PERFECT, GOOD or MISS, and it keeps score, combo and miss statistics for the seven-segment and VGA status displays. It sits beside the renderer in game mode and uses the same row-tick period.

## Interface
- `PERIOD`, default 100000: vga_clk cycles per row tick. Must equal the renderer's scroll period.
- `WINDOW`, default 3: late-hit grace, in ticks after note onset.
- `PTS_PERFECT`, default 2: points per PERFECT.
- `PTS_GOOD`, default 1: points per GOOD.
- `vga_clk`, in, 1: sole clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: single-cycle pulse that begins or restarts a round.
- `song_end`, in, 1: single-cycle pulse from the chart player that ends the round.
- `vga_bottom`, in, 10: bit [2+i] is the hit-line occupancy of lane i (i=0..6 is C..B). Bits [9] and [1:0] are ignored.
- `key`, in, 8: debounced keys. `key[7-i]` plays lane i. `key[0]` is unused.
- `state`, out, 2: 00 IDLE, 01 PLAY, 10 DONE.
- `score`, out, 16: binary, saturates at 65535.
- `combo`, out, 8: current streak, saturates at 255.
- `max_combo`, out, 8: best streak this round.
- `miss_cnt`, out, 8: misses this round, saturates at 255.
- `judge`, out, 2: last result. 00 none, 01 PERFECT, 10 GOOD, 11 MISS.
- `judge_valid`, out, 1: one-cycle pulse on every cycle that produces at least one judgement.

## Operation
- **Tick counter.** Counts 0..PERIOD-1 and then wraps. `tick` is registered high for the one cycle after the terminal count.
  - The counter is held at 0 outside PLAY and restarts from 0 on entry to PLAY.
- **FSM transitions.**
  - IDLE→PLAY on `start`.
  - PLAY→DONE on `song_end`.
  - DONE→PLAY on `start`.
  - Entering PLAY clears `score`, `combo`, `max_combo`, `miss_cnt`, `judge`, all lane state and the onset sample register.
  - `start` during PLAY restarts the round: it clears everything and stays in PLAY.
  - `song_end` outside PLAY is ignored.
  - `start` and `song_end` in the same cycle: `start` wins.
- **Onset detection.** At each tick, `vga_bottom[8:2]` is sampled into `bot_q`. An onset on lane i is `vga_bottom[2+i] & ~bot_q[i]` at a tick.
- **Lane state.** Each lane keeps an `armed` flag and a 2..8-bit `age`.
  - An onset sets `armed` and clears `age` to 0.
  - Each later tick increments `age` while the lane is armed.
- **Key edge.** `key_q` is registered every cycle. A press on lane i is `key[7-i] & ~key_q[7-i]`.
- **Judging in PLAY, per lane, per cycle:**
  - Press while armed: `age`==0 gives PERFECT; 1≤`age`≤WINDOW gives GOOD. The lane disarms.
  - Tick while armed with `age`==WINDOW and no press gives MISS. The lane disarms.
  - Onset while still armed and unjudged: the old note is judged MISS and the lane re-arms with `age` 0. If a press occurs in the same cycle, the old note is judged as a hit instead and the new note still arms.
  - A press in the same cycle as an expiry tick counts as a hit.
  - Press while unarmed: ghost press (see Configuration).
- **Aggregation across lanes in one cycle.**
  - `score` += sum of the points from all hits.
  - If any MISS occurred, `combo` is set to 0. Otherwise `combo` += number of hits.
  - `miss_cnt` += number of misses.
  - `max_combo` = max(`max_combo`, new `combo`).
  - `judge` = the worst result of the cycle, in the order MISS > GOOD > PERFECT.
  - `judge_valid` = 1.
- **IDLE/DONE.** All outputs hold. Keys and `vga_bottom` are ignored.

## Timing
- All outputs are registered.
- **Reset values.** `state`=IDLE, `score`=0, `combo`=0, `max_combo`=0, `miss_cnt`=0, `judge`=00, `judge_valid`=0. Lanes are disarmed, and `bot_q`=0 and `key_q`=0.
- **Key to result.** A key rise first sampled at edge k produces its result on the outputs after edge k+1 (two edges, one for the edge register and one for the judge register).
- **Miss timing.** An expiry MISS appears the cycle after the tick on which `age` would exceed WINDOW.
- **Reset mid-round.** Returns to IDLE immediately and clears everything.

## Configuration
- `JUDGE_GHOST_PENALTY_EN`
  - Defined: a press on an unarmed lane in PLAY is judged MISS. It increments `miss_cnt`, sets `combo` to 0, sets `judge`=11 and pulses `judge_valid`.
  - Undefined: ghost presses are ignored and produce no judgement.

## Test plan
(All scenarios use bench PERIOD=8 and WINDOW=3.)
- **Reset and start.** Assert `rst` mid-round; all outputs return to their reset values. Pulse `start`; `state`=01.
- **PERFECT.** Onset on lane C (`vga_bottom[2]` rises, seen at a tick), then `key[7]` rises before the next tick. Expect `judge`=01, `score`=2, `combo`=1, and a one-cycle `judge_valid`.
- **GOOD then MISS.** Lane D: press at `age`=2 gives `judge`=10 and `score`+1. Lane E: never pressed; after 4 ticks `judge`=11, `miss_cnt`=1, `combo`=0, and `max_combo` is kept.
- **Simultaneous lanes.** Lanes C and G get PERFECT in the same cycle while lane A expires. Expect `score`+4, `combo`=0, `miss_cnt`+1, `judge`=11, and a single `judge_valid` pulse.
- **Ghost press.** Press `key[1]` with lane B unarmed. With `JUDGE_GHOST_PENALTY_EN` defined: `miss_cnt`+1 and `combo`=0. Without it: outputs are unchanged and `judge_valid` stays 0.
- **Round control.** `song_end` gives `state`=10, and later key presses leave `score` frozen. Then `start` gives `state`=01 with all statistics at 0. Then 300 consecutive PERFECTs give `combo`=255 (saturated) and `score`=600.

Source files
------------

// File: rtl/game_judge.sv
// game_judge: per-lane PERFECT/GOOD/MISS judging with score/combo stats; define JUDGE_GHOST_PENALTY_EN to count empty-lane presses as MISS
module game_judge #(
    parameter int PERIOD      = 100000,
    parameter int WINDOW      = 3,
    parameter int PTS_PERFECT = 2,
    parameter int PTS_GOOD    = 1
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        song_end,
    input  logic [9:0]  vga_bottom,
    input  logic [7:0]  key,
    output logic [1:0]  state,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo,
    output logic [7:0]  miss_cnt,
    output logic [1:0]  judge,
    output logic        judge_valid
);
    localparam int AW_RAW = $clog2(WINDOW + 2);
    localparam int AW     = AW_RAW < 2 ? 2 : (AW_RAW > 8 ? 8 : AW_RAW);
    localparam int CW     = PERIOD > 1 ? $clog2(PERIOD) : 1;

    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DONE = 2'b10} st_t;

    st_t           st;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [6:0]    bot_q, press_r, armed;
    logic [7:0]    key_q;
    logic [AW-1:0] age [7];
    logic [6:0]    lane_bot, key_rise, onset, expire, perf_v, good_v, miss_v, ghost_v, hit;
    logic [3:0]    n_perf, n_good, n_miss, n_hit;
    logic [31:0]   pts, score_sum;
    logic [8:0]    combo_sum, miss_sum;
    logic [15:0]   score_nx;
    logic [7:0]    combo_nx, miss_nx, max_nx;
    logic [1:0]    judge_nx;
    logic          play, any_j;
    logic          unused;

    assign state  = st;
    assign unused = ^{vga_bottom[9], vga_bottom[1:0], key[0]};

    always_comb begin
        play     = st == PLAY;
        lane_bot = vga_bottom[8:2];
        onset    = (play && tick) ? lane_bot & ~bot_q : 7'd0;
        for (int i = 0; i < 7; i++) begin
            key_rise[i] = key[7-i] & ~key_q[7-i];
            expire[i]   = play & tick & armed[i] & (age[i] == AW'(WINDOW));
            perf_v[i]   = play & press_r[i] & armed[i] & (age[i] == '0);
            good_v[i]   = play & press_r[i] & armed[i] & (age[i] != '0);
        end
        hit = perf_v | good_v;
`ifdef JUDGE_GHOST_PENALTY_EN
        ghost_v = play ? press_r & ~armed : 7'd0;
`else
        ghost_v = 7'd0;
`endif
        // an unpressed armed lane misses either by expiry or by being overrun by a new onset
        miss_v    = (armed & ~press_r & (expire | onset)) | ghost_v;
        n_perf    = 4'($countones(perf_v));
        n_good    = 4'($countones(good_v));
        n_miss    = 4'($countones(miss_v));
        n_hit     = n_perf + n_good;
        any_j     = |{perf_v, good_v, miss_v};
        pts       = 32'(n_perf) * 32'(PTS_PERFECT) + 32'(n_good) * 32'(PTS_GOOD);
        score_sum = 32'(score) + pts;
        score_nx  = score_sum > 32'd65535 ? 16'hFFFF : score_sum[15:0];
        combo_sum = {1'b0, combo} + {5'd0, n_hit};
        combo_nx  = |miss_v ? 8'd0 : (combo_sum > 9'd255 ? 8'hFF : combo_sum[7:0]);
        miss_sum  = {1'b0, miss_cnt} + {5'd0, n_miss};
        miss_nx   = miss_sum > 9'd255 ? 8'hFF : miss_sum[7:0];
        max_nx    = combo_nx > max_combo ? combo_nx : max_combo;
        judge_nx  = |miss_v ? 2'b11 : (|good_v ? 2'b10 : 2'b01);
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            cnt         <= '0;
            tick        <= 1'b0;
            bot_q       <= '0;
            key_q       <= '0;
            press_r     <= '0;
            armed       <= '0;
            for (int i = 0; i < 7; i++) age[i] <= '0;
            score       <= '0;
            combo       <= '0;
            max_combo   <= '0;
            miss_cnt    <= '0;
            judge       <= 2'b00;
            judge_valid <= 1'b0;
        end else begin
            key_q       <= key;
            press_r     <= key_rise;
            judge_valid <= 1'b0;
            if (start) begin
                st        <= PLAY;
                cnt       <= '0;
                tick      <= 1'b0;
                bot_q     <= '0;
                press_r   <= '0;
                armed     <= '0;
                for (int i = 0; i < 7; i++) age[i] <= '0;
                score     <= '0;
                combo     <= '0;
                max_combo <= '0;
                miss_cnt  <= '0;
                judge     <= 2'b00;
            end else if (play) begin
                if (song_end) st <= DONE;
                cnt  <= cnt == CW'(PERIOD - 1) ? '0 : cnt + CW'(1);
                tick <= cnt == CW'(PERIOD - 1);
                if (tick) bot_q <= lane_bot;
                for (int i = 0; i < 7; i++) begin
                    if (onset[i]) begin
                        armed[i] <= 1'b1;
                        age[i]   <= '0;
                    end else if (hit[i] | miss_v[i]) begin
                        armed[i] <= 1'b0;
                    end else if (tick & armed[i]) begin
                        age[i] <= age[i] + AW'(1);
                    end
                end
                if (any_j) begin
                    score       <= score_nx;
                    combo       <= combo_nx;
                    max_combo   <= max_nx;
                    miss_cnt    <= miss_nx;
                    judge       <= judge_nx;
                    judge_valid <= 1'b1;
                end
            end else begin
                cnt  <= '0;
                tick <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_game_judge.sv
// tb_game_judge: directed checks of game_judge with PERIOD=8, WINDOW=3 (ticks land on edge 8k+1 after start)
module tb_game_judge;
    logic        clk = 1'b0;
    logic        rst, start, song_end;
    logic [9:0]  vga_bottom;
    logic [7:0]  key;
    logic [1:0]  state, judge;
    logic [15:0] score;
    logic [7:0]  combo, max_combo, miss_cnt;
    logic        judge_valid;
    int          n_chk = 0;
    int          n_fail = 0;

    game_judge #(.PERIOD(8), .WINDOW(3), .PTS_PERFECT(2), .PTS_GOOD(1)) dut (
        .vga_clk(clk), .rst(rst), .start(start), .song_end(song_end),
        .vga_bottom(vga_bottom), .key(key), .state(state), .score(score),
        .combo(combo), .max_combo(max_combo), .miss_cnt(miss_cnt),
        .judge(judge), .judge_valid(judge_valid)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        n_chk++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset state: got %b want 00", state); end
        n_chk++; if ({score, combo, max_combo, miss_cnt, judge, judge_valid} !== 43'd0) begin n_fail++; $display("FAIL reset stats: got %h want 0", {score, combo, max_combo, miss_cnt, judge, judge_valid}); end
        rst = 1'b0;
        step(1);
        do_start;
        n_chk++; if (state !== 2'b01) begin n_fail++; $display("FAIL start state: got %b want 01", state); end
        vga_bottom = 10'h004;
        step(10);
        key = 8'h80;
        step(1);
        key = 8'h00;
        step(1);
        n_chk++; if (judge_valid !== 1'b1) begin n_fail++; $display("FAIL pre-reset valid: got %b want 1", judge_valid); end
        rst = 1'b1;
        #1;
        n_chk++; if (state !== 2'b00) begin n_fail++; $display("FAIL async reset state: got %b want 00", state); end
        n_chk++; if ({score, combo, max_combo, miss_cnt, judge, judge_valid} !== 43'd0) begin n_fail++; $display("FAIL async reset stats: got %h want 0", {score, combo, max_combo, miss_cnt, judge, judge_valid}); end
        vga_bottom = '0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_perfect;
        do_start;
        vga_bottom = 10'h004;
        step(10);
        key = 8'h80;
        step(1);
        key = 8'h00;
        n_chk++; if (judge_valid !== 1'b0) begin n_fail++; $display("FAIL perfect early valid: got %b want 0", judge_valid); end
        step(1);
        n_chk++; if (judge !== 2'b01) begin n_fail++; $display("FAIL perfect judge: got %b want 01", judge); end
        n_chk++; if (score !== 16'd2) begin n_fail++; $display("FAIL perfect score: got %0d want 2", score); end
        n_chk++; if (combo !== 8'd1) begin n_fail++; $display("FAIL perfect combo: got %0d want 1", combo); end
        n_chk++; if (max_combo !== 8'd1) begin n_fail++; $display("FAIL perfect max_combo: got %0d want 1", max_combo); end
        n_chk++; if (judge_valid !== 1'b1) begin n_fail++; $display("FAIL perfect valid: got %b want 1", judge_valid); end
        step(1);
        n_chk++; if (judge_valid !== 1'b0) begin n_fail++; $display("FAIL perfect valid pulse: got %b want 0", judge_valid); end
    endtask

    task automatic test_good_miss;
        do_start;
        vga_bottom = 10'h018;
        step(26);
        key = 8'h40;
        step(1);
        key = 8'h00;
        step(1);
        n_chk++; if (judge !== 2'b10) begin n_fail++; $display("FAIL good judge: got %b want 10", judge); end
        n_chk++; if (score !== 16'd1) begin n_fail++; $display("FAIL good score: got %0d want 1", score); end
        n_chk++; if (judge_valid !== 1'b1) begin n_fail++; $display("FAIL good valid: got %b want 1", judge_valid); end
        step(12);
        n_chk++; if ({judge, miss_cnt} !== {2'b10, 8'd0}) begin n_fail++; $display("FAIL miss early: got judge %b miss %0d want 10/0", judge, miss_cnt); end
        step(1);
        n_chk++; if (judge !== 2'b11) begin n_fail++; $display("FAIL miss judge: got %b want 11", judge); end
        n_chk++; if (miss_cnt !== 8'd1) begin n_fail++; $display("FAIL miss miss_cnt: got %0d want 1", miss_cnt); end
        n_chk++; if (combo !== 8'd0) begin n_fail++; $display("FAIL miss combo: got %0d want 0", combo); end
        n_chk++; if (max_combo !== 8'd1) begin n_fail++; $display("FAIL miss max_combo: got %0d want 1", max_combo); end
        n_chk++; if ({score, judge_valid} !== {16'd1, 1'b1}) begin n_fail++; $display("FAIL miss score/valid: got %0d/%b want 1/1", score, judge_valid); end
    endtask

    task automatic test_simultaneous;
        do_start;
        n_chk++; if (score !== 16'd0) begin n_fail++; $display("FAIL restart score: got %0d want 0", score); end
        vga_bottom = 10'h080;
        step(26);
        vga_bottom = 10'h0C4;
        step(13);
        key = 8'h88;
        step(1);
        key = 8'h00;
        step(1);
        n_chk++; if (score !== 16'd4) begin n_fail++; $display("FAIL simul score: got %0d want 4", score); end
        n_chk++; if (combo !== 8'd0) begin n_fail++; $display("FAIL simul combo: got %0d want 0", combo); end
        n_chk++; if (miss_cnt !== 8'd1) begin n_fail++; $display("FAIL simul miss_cnt: got %0d want 1", miss_cnt); end
        n_chk++; if (judge !== 2'b11) begin n_fail++; $display("FAIL simul judge: got %b want 11", judge); end
        n_chk++; if (judge_valid !== 1'b1) begin n_fail++; $display("FAIL simul valid: got %b want 1", judge_valid); end
        step(1);
        n_chk++; if (judge_valid !== 1'b0) begin n_fail++; $display("FAIL simul valid pulse: got %b want 0", judge_valid); end
    endtask

    task automatic test_ghost;
        do_start;
        n_chk++; if ({combo, miss_cnt} !== 16'd0) begin n_fail++; $display("FAIL restart combo/miss: got %0d/%0d want 0/0", combo, miss_cnt); end
        vga_bottom = 10'h004;
        step(10);
        key = 8'h80;
        step(1);
        key = 8'h00;
        step(1);
        n_chk++; if (combo !== 8'd1) begin n_fail++; $display("FAIL ghost pre combo: got %0d want 1", combo); end
        key = 8'h02;
        step(1);
        key = 8'h00;
        step(1);
`ifdef JUDGE_GHOST_PENALTY_EN
        n_chk++; if (miss_cnt !== 8'd1) begin n_fail++; $display("FAIL ghost miss_cnt: got %0d want 1", miss_cnt); end
        n_chk++; if (combo !== 8'd0) begin n_fail++; $display("FAIL ghost combo: got %0d want 0", combo); end
        n_chk++; if ({judge, judge_valid} !== 3'b111) begin n_fail++; $display("FAIL ghost judge/valid: got %b/%b want 11/1", judge, judge_valid); end
`else
        n_chk++; if (miss_cnt !== 8'd0) begin n_fail++; $display("FAIL ghost miss_cnt: got %0d want 0", miss_cnt); end
        n_chk++; if (combo !== 8'd1) begin n_fail++; $display("FAIL ghost combo: got %0d want 1", combo); end
        n_chk++; if ({judge, judge_valid} !== 3'b010) begin n_fail++; $display("FAIL ghost judge/valid: got %b/%b want 01/0", judge, judge_valid); end
`endif
        n_chk++; if (score !== 16'd2) begin n_fail++; $display("FAIL ghost score: got %0d want 2", score); end
    endtask

    task automatic test_round_control;
        do_start;
        vga_bottom = 10'h00C;
        step(10);
        key = 8'h80;
        step(1);
        key = 8'h00;
        step(1);
        song_end = 1'b1;
        step(1);
        song_end = 1'b0;
        n_chk++; if (state !== 2'b10) begin n_fail++; $display("FAIL song_end state: got %b want 10", state); end
        key = 8'h40;
        step(1);
        key = 8'h00;
        step(2);
        n_chk++; if (score !== 16'd2) begin n_fail++; $display("FAIL done frozen score: got %0d want 2", score); end
        n_chk++; if ({combo, judge_valid} !== {8'd1, 1'b0}) begin n_fail++; $display("FAIL done frozen combo/valid: got %0d/%b want 1/0", combo, judge_valid); end
        song_end = 1'b1;
        step(1);
        song_end = 1'b0;
        n_chk++; if (state !== 2'b10) begin n_fail++; $display("FAIL done song_end state: got %b want 10", state); end
        start = 1'b1;
        song_end = 1'b1;
        step(1);
        start = 1'b0;
        song_end = 1'b0;
        n_chk++; if (state !== 2'b01) begin n_fail++; $display("FAIL restart state: got %b want 01", state); end
        n_chk++; if ({score, combo, max_combo, miss_cnt, judge} !== 42'd0) begin n_fail++; $display("FAIL restart stats: got %h want 0", {score, combo, max_combo, miss_cnt, judge}); end
        vga_bottom = '0;
        step(1);
        for (int n = 0; n < 300; n++) begin
            vga_bottom = 10'h004;
            step(9);
            key = 8'h80;
            step(1);
            key = 8'h00;
            vga_bottom = '0;
            step(6);
        end
        n_chk++; if (combo !== 8'd255) begin n_fail++; $display("FAIL sat combo: got %0d want 255", combo); end
        n_chk++; if (max_combo !== 8'd255) begin n_fail++; $display("FAIL sat max_combo: got %0d want 255", max_combo); end
        n_chk++; if (score !== 16'd600) begin n_fail++; $display("FAIL sat score: got %0d want 600", score); end
        n_chk++; if ({miss_cnt, judge} !== {8'd0, 2'b01}) begin n_fail++; $display("FAIL sat miss/judge: got %0d/%b want 0/01", miss_cnt, judge); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        song_end = 1'b0;
        vga_bottom = '0;
        key = '0;
        test_reset;
        test_perfect;
        test_good_miss;
        test_simultaneous;
        test_ghost;
        test_round_control;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
